// File: rtl/alu_control_muldiv.sv
// ALU control decode (RV32I) plus an iterative RV32M multiply/divide sequencer.
// Define MULDIV_DIV_EN to build the restoring divider; without it, DIV/REM ops finish at once with result 0.
module alu_control_muldiv #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      ALUOp,
    input  logic [4:0]      funct,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [2:0]      ALUControl,
    output logic            sub,
    output logic            md_sel,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int K  = MUL_BITS_PER_CYCLE;
    localparam logic [CW-1:0] N_MUL = CW'(XLEN / K);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;      // doubles as the multiplier shift register
    logic [2:0]      f3_reg;
    logic [XLEN+1:0] hi;         // upper product half, two guard bits for signed sums
    logic [XLEN+1:0] hi_nxt;
    logic [XLEN+1:0] a_ext;
    logic [XLEN-1:0] lo_nxt;
    logic [XLEN-1:0] mul_res;
    logic [XLEN-1:0] div_res;
    logic [XLEN-1:0] result;
    logic            accept;
    logic            a_signed;
    logic            b_signed;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        cond_neg = neg ? (~v + XLEN'(1)) : v;
    endfunction

    // ALUControl / sub / md_sel decode from main-control ALUOp and funct bits.
    always_comb begin
        ALUControl = 3'b000;
        sub        = 1'b0;
        md_sel     = 1'b0;
        case (ALUOp)
            3'b000, 3'b001: begin
                if ((ALUOp == 3'b000) && funct[4]) begin
                    md_sel = 1'b1;
                end else begin
                    case (funct[2:0])
                        3'b000:         sub = (ALUOp == 3'b000) ? funct[3] : 1'b0;
                        3'b001:         ALUControl = 3'b110;
                        3'b010, 3'b011: begin
                            ALUControl = 3'b001;
                            sub        = 1'b1;
                        end
                        3'b100:         ALUControl = 3'b100;
                        3'b101:         ALUControl = funct[3] ? 3'b101 : 3'b111;
                        3'b110:         ALUControl = 3'b011;
                        3'b111:         ALUControl = 3'b010;
                        default:        ALUControl = 3'b000;
                    endcase
                end
            end
            3'b100:  sub = 1'b1;
            default: sub = 1'b0;
        endcase
    end

    assign accept  = (state == IDLE) && in_valid && md_sel && !flush;
    assign md_busy = in_valid && md_sel && (state != DONE);

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencer next-state logic; flush overrides every state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_DIV_EN
                    next_state = BUSY;
`else
                    next_state = funct[2] ? DONE : BUSY;
`endif
                end else begin
                    next_state = IDLE;
                end
            end
            BUSY: begin
                if (cnt == ONE) begin
                    next_state = DONE;
                end else begin
                    next_state = BUSY;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end else begin
            next_state = next_state;
        end
    end

    assign a_signed = (f3_reg == 3'b001) || (f3_reg == 3'b010);
    assign b_signed = (f3_reg == 3'b001);

    // Right-shifting multiplier; the sign bit of a signed multiplier carries negative weight.
    always_comb begin
        a_ext  = a_signed ? {{2{a_reg[XLEN-1]}}, a_reg} : {2'b00, a_reg};
        hi_nxt = hi;
        lo_nxt = b_reg;
        for (int j = 0; j < K; j++) begin
            if (lo_nxt[0]) begin
                if (b_signed && (cnt == ONE) && (j == K - 1)) begin
                    hi_nxt = hi_nxt - a_ext;
                end else begin
                    hi_nxt = hi_nxt + a_ext;
                end
            end else begin
                hi_nxt = hi_nxt;
            end
            lo_nxt = {hi_nxt[0], lo_nxt[XLEN-1:1]};
            hi_nxt = {hi_nxt[XLEN+1], hi_nxt[XLEN+1:1]};
        end
        mul_res = (f3_reg[1:0] == 2'b00) ? lo_nxt : hi_nxt[XLEN-1:0];
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quot_nxt;
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            div_ovf;
    logic            sgn_in;

    assign sgn_in = !funct[0];

    // Divider registers: magnitudes are divided, sign and special-case flags captured at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            quot     <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (accept) begin
            rem      <= '0;
            quot     <= cond_neg(op_a, sgn_in && op_a[XLEN-1]);
            dvs      <= cond_neg(op_b, sgn_in && op_b[XLEN-1]);
            neg_q    <= sgn_in && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_r    <= sgn_in && op_a[XLEN-1];
            div_zero <= (op_b == '0);
            div_ovf  <= sgn_in && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        end else if ((state == BUSY) && !flush) begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
        end
    end

    // One restoring step, then the sign fix-up and special-case override for the final step.
    always_comb begin
        r_sh     = {rem, quot[XLEN-1]};
        diff     = r_sh - {1'b0, dvs};
        rem_nxt  = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
        quot_nxt = {quot[XLEN-2:0], ~diff[XLEN]};
        if (div_zero) begin
            q_fix = '1;
            r_fix = a_reg;
        end else if (div_ovf) begin
            q_fix = {1'b1, {(XLEN-1){1'b0}}};
            r_fix = '0;
        end else begin
            q_fix = cond_neg(quot_nxt, neg_q);
            r_fix = cond_neg(rem_nxt, neg_r);
        end
        div_res = f3_reg[1] ? r_fix : q_fix;
    end
`else
    assign div_res = '0;
`endif

    assign result = f3_reg[2] ? div_res : mul_res;

    // Operand capture, iteration count, multiplier state and the registered result/done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            f3_reg    <= 3'b000;
            hi        <= '0;
            md_result <= '0;
            md_done   <= 1'b0;
        end else begin
            md_done <= (next_state == DONE);
            if (accept) begin
                a_reg  <= op_a;
                b_reg  <= op_b;
                f3_reg <= funct[2:0];
                hi     <= '0;
                if (funct[2]) begin
`ifdef MULDIV_DIV_EN
                    cnt <= CW'(XLEN);
`else
                    cnt       <= '0;
                    md_result <= '0;
`endif
                end else begin
                    cnt <= N_MUL;
                end
            end else if ((state == BUSY) && !flush) begin
                cnt   <= cnt - ONE;
                hi    <= hi_nxt;
                b_reg <= lo_nxt;
                if (cnt == ONE) begin
                    md_result <= result;
                end
            end else if (flush) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench for alu_control_muldiv: decode table, M-op latency/results via a result scoreboard, flush and reset.
module tb_alu_control_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ALUOp;
    logic [4:0]  funct;
    logic        in_valid;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  ALUControl;
    logic        sub;
    logic        md_sel;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_control_muldiv #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct(funct), .in_valid(in_valid),
        .flush(flush), .op_a(op_a), .op_b(op_b), .ALUControl(ALUControl), .sub(sub),
        .md_sel(md_sel), .md_busy(md_busy), .md_done(md_done), .md_result(md_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic [2:0] aop, input logic [4:0] fn,
                           input logic iv, input logic [2:0] ctl, input logic sb, input logic sel);
        ALUOp = aop; funct = fn; in_valid = iv;
        #1;
        check({tag, ".ctl"},  {29'd0, ALUControl}, {29'd0, ctl});
        check({tag, ".sub"},  {31'd0, sub},        {31'd0, sb});
        check({tag, ".sel"},  {31'd0, md_sel},     {31'd0, sel});
        check({tag, ".busy"}, {31'd0, md_busy},    32'd0);
        in_valid = 1'b0;
        step();
    endtask

    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int stall);
        int          busy_n;
        bit          seen;
        logic [31:0] want;
        exp_q.push_back(exp);
        ALUOp = 3'b000; funct = {2'b10, f3}; op_a = a; op_b = b; in_valid = 1'b1;
        #1;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (md_done) begin
                seen = 1'b1;
                break;
            end
            if (md_busy) busy_n++;
            step();
        end
        want = exp_q.pop_front();
        check({tag, ".done"},   {31'd0, seen},    32'd1);
        check({tag, ".stall"},  32'(busy_n),      32'(stall));
        check({tag, ".nobusy"}, {31'd0, md_busy}, 32'd0);
        check({tag, ".result"}, md_result,        want);
        in_valid = 1'b0;
        step();
        check({tag, ".pulse"},  {31'd0, md_done}, 32'd0);
        check({tag, ".hold"},   md_result,        want);
        last_res = want;
    endtask

    task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
`ifdef MULDIV_DIV_EN
        run_md(tag, f3, a, b, exp, 33);
`else
        run_md(tag, f3, a, b, 32'h0000_0000, 1);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; ALUOp = 3'b000; funct = 5'b00000; in_valid = 1'b0; flush = 1'b0;
        op_a = 32'd0; op_b = 32'd0; last_res = 32'd0;
        step();
        step();
        check("reset.done",   {31'd0, md_done}, 32'd0);
        check("reset.result", md_result,        32'd0);
        check("reset.busy",   {31'd0, md_busy}, 32'd0);
        rst = 1'b0;
        step();

        chk_dec("r_sub",  3'b000, 5'b01000, 1'b1, 3'b000, 1'b1, 1'b0);
        chk_dec("srai",   3'b001, 5'b01101, 1'b1, 3'b101, 1'b0, 1'b0);
        chk_dec("r_add",  3'b000, 5'b00000, 1'b1, 3'b000, 1'b0, 1'b0);
        chk_dec("addi",   3'b001, 5'b01000, 1'b1, 3'b000, 1'b0, 1'b0);
        chk_dec("sll",    3'b000, 5'b00001, 1'b1, 3'b110, 1'b0, 1'b0);
        chk_dec("slt",    3'b000, 5'b00010, 1'b1, 3'b001, 1'b1, 1'b0);
        chk_dec("sltiu",  3'b001, 5'b00011, 1'b1, 3'b001, 1'b1, 1'b0);
        chk_dec("xor",    3'b000, 5'b00100, 1'b1, 3'b100, 1'b0, 1'b0);
        chk_dec("srl",    3'b000, 5'b00101, 1'b1, 3'b111, 1'b0, 1'b0);
        chk_dec("sra",    3'b000, 5'b01101, 1'b1, 3'b101, 1'b0, 1'b0);
        chk_dec("or",     3'b000, 5'b00110, 1'b1, 3'b011, 1'b0, 1'b0);
        chk_dec("andi",   3'b001, 5'b00111, 1'b1, 3'b010, 1'b0, 1'b0);
        chk_dec("branch", 3'b100, 5'b00111, 1'b1, 3'b000, 1'b1, 1'b0);
        chk_dec("other",  3'b010, 5'b01111, 1'b1, 3'b000, 1'b0, 1'b0);
        chk_dec("mop",    3'b000, 5'b10001, 1'b0, 3'b000, 1'b0, 1'b1);
        chk_dec("slli_h", 3'b001, 5'b10001, 1'b1, 3'b110, 1'b0, 1'b0);

        run_md("mul",     3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_md("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_md("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_md("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_md("mulhsu2", 3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 33);

        run_div("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_div("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_div("divu0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run_div("remu0",   3'b111, 32'd5,         32'd0,         32'd5);
        run_div("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("divu",    3'b101, 32'd100,       32'd7,         32'd14);
        run_div("remu",    3'b111, 32'd100,       32'd7,         32'd2);
        run_div("div_nb",  3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_div("rem_nb",  3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1);
        run_div("rem_z",   3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);

        run_md("mul_nz", 3'b000, 32'd9, 32'd11, 32'd99, 33);
        ALUOp = 3'b000; funct = 5'b10000; op_a = 32'd5; op_b = 32'd6; in_valid = 1'b1;
        step();
        repeat (9) step();
        flush = 1'b1; in_valid = 1'b0;
        step();
        flush = 1'b0;
        check("flush.done",   {31'd0, md_done}, 32'd0);
        check("flush.result", md_result,        last_res);
        seen = 1'b0;
        repeat (40) begin
            if (md_done) seen = 1'b1;
            step();
        end
        check("flush.nodone", {31'd0, seen}, 32'd0);
        check("flush.hold",   md_result,     last_res);
        run_md("mul3x4", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        ALUOp = 3'b000; funct = 5'b10100; op_a = 32'd100; op_b = 32'd3; in_valid = 1'b1;
        repeat (5) step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        check("rst.done",   {31'd0, md_done}, 32'd0);
        check("rst.result", md_result,        32'd0);
        check("rst.busy",   {31'd0, md_busy}, 32'd0);
        rst = 1'b0;
        step();
        check("rst.hold", md_result, 32'd0);
        run_md("mulhu_rst", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
